// File: rtl/mac_out_drain_if.sv
// Handshake bundle between the MAC array result port, the lane drain block
// and its downstream consumer. The drain block takes the slave side: it
// receives packed results and returns unpacked lanes. The master side is the
// MAC-array/consumer view (a bench plays this role).
interface mac_out_drain_if #(
    parameter int Z_WIDTH = 320
);
    logic [Z_WIDTH-1:0] z;
    logic [3:0]         prec;
    logic               z_valid;
    logic               out_ready;
    logic               out_valid;
    logic [Z_WIDTH-1:0] out_data;
    logic [3:0]         out_idx;
    logic               out_last;
    logic               busy;
    logic               overrun;

    modport slave (
        input  z, prec, z_valid, out_ready,
        output out_valid, out_data, out_idx, out_last, busy, overrun
    );

    modport master (
        output z, prec, z_valid, out_ready,
        input  out_valid, out_data, out_idx, out_last, busy, overrun
    );
endinterface

// File: rtl/mac_out_drain.sv
// Drains one packed MAC accumulator word as a stream of extended lanes.
// The precision code decides how many lanes (1..16) the word is split into.
// A new word may be captured on the same cycle as the last beat of the
// current one, so back-to-back results stream without a bubble; any other
// result arriving mid-drain is dropped and flagged on the sticky overrun.
module mac_out_drain #(
    parameter int Z_WIDTH = 320,
    parameter bit SIGNED  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mac_out_drain_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Lane-count exponent per operand: 8b -> 0, 4b -> 1, 2b -> 2.
    function automatic logic [2:0] prec_log(input logic [1:0] code);
        logic [2:0] r;
        case (code)
            2'b10:   r = 3'd1;
            2'b11:   r = 3'd2;
            default: r = 3'd0;
        endcase
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [Z_WIDTH-1:0] word_q, word_d;      // captured accumulator word
    logic [2:0]         nlog_q, nlog_d;      // log2 of lane count
    logic [3:0]         idx_q, idx_d;        // lane currently presented
    logic               overrun_q, overrun_d;

    logic               out_valid_q, out_valid_d;
    logic [Z_WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]         out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;

    logic               fire;
    logic               last_fire;

    // Extended lane candidates, one per possible lane count; the output
    // mux picks one using the next-state lane count. Each candidate is
    // built from the next-state word/index so the output flops present the
    // lane that matches the state being entered.
    logic [4:0][Z_WIDTH-1:0] cand;

    for (genvar k = 0; k < 5; k++) begin : g_lane
        localparam int LW = Z_WIDTH >> k;
        logic [LW-1:0] lane;

        assign lane = LW'(word_d >> (LW * 32'(idx_d)));

        if (k == 0) begin : g_full
            assign cand[k] = lane;
        end else if (SIGNED) begin : g_sext
            assign cand[k] = {{(Z_WIDTH-LW){lane[LW-1]}}, lane};
        end else begin : g_zext
            assign cand[k] = {{(Z_WIDTH-LW){1'b0}}, lane};
        end
    end

    // FSM next state: capture, lane advance, drain exit and overrun detect.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        nlog_d    = nlog_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        fire      = out_valid_q && bus.out_ready;
        last_fire = fire && out_last_q;

        case (state_q)
            IDLE: begin
                if (bus.z_valid) begin
                    state_d = DRAIN;
                    word_d  = bus.z;
                    nlog_d  = prec_log(bus.prec[3:2]) + prec_log(bus.prec[1:0]);
                    idx_d   = 4'd0;
                end
            end
            DRAIN: begin
                if (last_fire) begin
                    // The final beat is the one slot where a new word fits.
                    if (bus.z_valid) begin
                        word_d = bus.z;
                        nlog_d = prec_log(bus.prec[3:2]) + prec_log(bus.prec[1:0]);
                        idx_d  = 4'd0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                    end
                end else begin
                    if (fire) begin
                        idx_d = idx_q + 4'd1;
                    end
                    if (bus.z_valid) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register inputs: lane data, index and last flag for the next cycle.
    always_comb begin
        out_valid_d = (state_d == DRAIN);
        out_idx_d   = idx_d;
        out_last_d  = 1'b0;
        out_data_d  = '0;
        if (state_d == DRAIN) begin
            out_last_d = (idx_d == 4'((5'd1 << nlog_d) - 5'd1));
            case (nlog_d)
                3'd0:    out_data_d = cand[0];
                3'd1:    out_data_d = cand[1];
                3'd2:    out_data_d = cand[2];
                3'd3:    out_data_d = cand[3];
                3'd4:    out_data_d = cand[4];
                default: out_data_d = cand[0];
            endcase
        end
    end

    // State and output registers; reset wins over everything including z_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            nlog_q      <= 3'd0;
            idx_q       <= 4'd0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            nlog_q      <= nlog_d;
            idx_q       <= idx_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == DRAIN);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mac_out_drain.sv
// Bench for mac_out_drain at Z_WIDTH=64, SIGNED=1. A queue-based model holds
// the beats still owed to the consumer; a negedge process compares the DUT
// against it every cycle, and the directed sequence pins literal values.
module tb_mac_out_drain;

    localparam int ZW = 64;

    typedef struct {
        logic [ZW-1:0] data;
        logic [3:0]    idx;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    beat_t mq[$];
    logic  m_ovr = 1'b0;

    logic [ZW-1:0] exp4 [4] = '{64'hFFFF_FFFF_FFFF_8000, 64'h0000_0000_0000_7FFF,
                                64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFF};

    mac_out_drain_if #(.Z_WIDTH(ZW)) bus ();

    mac_out_drain #(.Z_WIDTH(ZW), .SIGNED(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [ZW-1:0] act, input logic [ZW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Split a word into its lanes by plain arithmetic and queue them.
    task automatic push_word(input logic [ZW-1:0] w, input logic [3:0] p);
        int na, nw, n, lw;
        na = (p[3:2] == 2'b10) ? 2 : (p[3:2] == 2'b11) ? 4 : 1;
        nw = (p[1:0] == 2'b10) ? 2 : (p[1:0] == 2'b11) ? 4 : 1;
        n  = na * nw;
        lw = ZW / n;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            logic [ZW-1:0] v, m;
            v = w >> (i * lw);
            if (lw < ZW) begin
                m = (64'd1 << lw) - 64'd1;
                v = v & m;
                if (v[lw-1]) v = v | ~m;
            end
            b.data = v;
            b.idx  = i[3:0];
            b.last = (i == n - 1);
            mq.push_back(b);
        end
    endtask

    // Model: pop on handshake; a result is taken only if nothing remains owed.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovr <= 1'b0;
        end else begin
            if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
            if (bus.z_valid) begin
                if (mq.size() == 0) push_word(bus.z, bus.prec);
                else m_ovr <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (en) begin
            chk("m_valid", bus.out_valid, mq.size() != 0);
            chk("m_busy", bus.busy, mq.size() != 0);
            chk("m_overrun", bus.overrun, m_ovr);
            if (mq.size() != 0) begin
                chk("m_data", bus.out_data, mq[0].data);
                chk("m_idx", bus.out_idx, mq[0].idx);
                chk("m_last", bus.out_last, mq[0].last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got;
        rst = 1'b1;
        bus.z = '0;
        bus.prec = 4'b0000;
        bus.z_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        en = 1'b1;
        step();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_data", bus.out_data, 64'h0);
        rst = 1'b0;
        step();

        // 8b x 8b: single beat carrying the whole word
        bus.prec = 4'b0000;
        bus.z = 64'h8000_0000_0000_0001;
        bus.z_valid = 1'b1;
        step();
        bus.z_valid = 1'b0;
        chk("8x8_valid", bus.out_valid, 1'b1);
        chk("8x8_data", bus.out_data, 64'h8000_0000_0000_0001);
        chk("8x8_idx", bus.out_idx, 4'd0);
        chk("8x8_last", bus.out_last, 1'b1);
        step();
        chk("8x8_done", bus.out_valid, 1'b0);

        // 4b x 4b: four sign-extended 16-bit lanes; inputs change mid-drain
        bus.prec = 4'b1010;
        bus.z = 64'hFFFF_0003_7FFF_8000;
        bus.z_valid = 1'b1;
        step();
        bus.z_valid = 1'b0;
        bus.z = 64'h0;
        bus.prec = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            chk("4x4_data", bus.out_data, exp4[k]);
            chk("4x4_idx", bus.out_idx, k[3:0]);
            chk("4x4_last", bus.out_last, k == 3);
            step();
        end
        chk("4x4_done", bus.out_valid, 1'b0);

        // 2b x 2b: sixteen 4-bit lanes with toggling ready
        bus.prec = 4'b1111;
        bus.z = 64'hFEDC_BA98_7654_3210;
        bus.z_valid = 1'b1;
        step();
        bus.z_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 64 && got < 16; c++) begin
            bus.out_ready = (c % 2 == 0);
            if (bus.out_valid && bus.out_ready) begin
                chk("2x2_data", bus.out_data, (got < 8) ? 64'(got) : 64'(got) - 64'd16);
                chk("2x2_idx", bus.out_idx, got[3:0]);
                got++;
            end
            step();
        end
        bus.out_ready = 1'b1;
        chk("2x2_count", 64'(got), 64'd16);
        chk("2x2_done", bus.out_valid, 1'b0);

        // Back-to-back: B captured on A's last transfer
        bus.prec = 4'b1010;
        bus.z = 64'h0004_0003_0002_0001;
        bus.z_valid = 1'b1;
        step();
        bus.z_valid = 1'b0;
        step();
        step();
        step();
        chk("b2b_pre_last", bus.out_last, 1'b1);
        bus.z_valid = 1'b1;
        bus.prec = 4'b0000;
        bus.z = 64'hDEAD_BEEF_0BAD_F00D;
        step();
        bus.z_valid = 1'b0;
        chk("b2b_valid", bus.out_valid, 1'b1);
        chk("b2b_idx", bus.out_idx, 4'd0);
        chk("b2b_data", bus.out_data, 64'hDEAD_BEEF_0BAD_F00D);
        chk("b2b_overrun", bus.overrun, 1'b0);
        step();
        chk("b2b_done", bus.out_valid, 1'b0);

        // Overrun: result arriving at idx 1 is dropped
        bus.prec = 4'b1010;
        bus.z = 64'h1111_2222_3333_4444;
        bus.z_valid = 1'b1;
        step();
        bus.z_valid = 1'b0;
        step();
        chk("ovr_idx1", bus.out_idx, 4'd1);
        bus.z_valid = 1'b1;
        bus.z = 64'h9999_9999_9999_9999;
        bus.prec = 4'b1111;
        step();
        bus.z_valid = 1'b0;
        chk("ovr_flag", bus.overrun, 1'b1);
        chk("ovr_idx2", bus.out_idx, 4'd2);
        chk("ovr_data2", bus.out_data, 64'h2222);
        step();
        chk("ovr_data3", bus.out_data, 64'h1111);
        chk("ovr_last3", bus.out_last, 1'b1);
        step();
        chk("ovr_done", bus.out_valid, 1'b0);
        chk("ovr_sticky", bus.overrun, 1'b1);

        // Reset mid-drain, with z_valid during reset ignored
        bus.prec = 4'b1111;
        bus.z = 64'h0123_4567_89AB_CDEF;
        bus.z_valid = 1'b1;
        step();
        bus.z_valid = 1'b0;
        step();
        rst = 1'b1;
        bus.z_valid = 1'b1;
        step();
        rst = 1'b0;
        bus.z_valid = 1'b0;
        chk("rstm_valid", bus.out_valid, 1'b0);
        chk("rstm_busy", bus.busy, 1'b0);
        chk("rstm_overrun", bus.overrun, 1'b0);
        chk("rstm_idx", bus.out_idx, 4'd0);
        step();
        chk("rstm_ignored", bus.out_valid, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_out_drain.md
MAC_OUT_DRAIN -- requirements
Module: mac_out_drain

Interface
REQ-001 Parameter Z_WIDTH, default 320: width of the packed MAC accumulator word z; SHALL be divisible by 16.
REQ-002 Parameter SIGNED, default 1: 1 means lanes are sign-extended, 0 means lanes are zero-extended.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 z  input  Z_WIDTH  packed accumulator word from the MAC array output.
REQ-006 prec  input  4  precision code: [3:2] activation, [1:0] weight; 00 = 8b, 10 = 4b, 11 = 2b, 01 = 8b.
REQ-007 z_valid  input  1  single-cycle pulse: z holds a final accumulated result.
REQ-008 out_ready  input  1  downstream ready.
REQ-009 out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-010 out_data  output  Z_WIDTH  one unpacked lane, extended to Z_WIDTH.
REQ-011 out_idx  output  4  index of the current lane.
REQ-012 out_last  output  1  current lane is the final lane of the word.
REQ-013 busy  output  1  high while in DRAIN.
REQ-014 overrun  output  1  sticky flag: a result was dropped.

Function
REQ-015 The FSM SHALL have two states, IDLE and DRAIN.
REQ-016 Lane count N SHALL be na*nw, where na and nw are each 1 for code 00/01, 2 for 10 and 4 for 11, so N is one of {1,2,4,8,16}.
REQ-017 Lane width SHALL be LW = Z_WIDTH/N; lane i SHALL be z[i*LW +: LW].
REQ-018 Capture: in IDLE with z_valid=1, the block SHALL register z and the decoded N, enter DRAIN with idx=0, and assert out_valid on the next cycle.
REQ-019 prec and z SHALL be sampled only at capture; changes during DRAIN SHALL have no effect.
REQ-020 out_data, out_idx, out_last and out_valid SHALL be registered outputs, with no combinational path from any input.
REQ-021 out_data SHALL be lane idx of the captured word, sign-extended when SIGNED=1 and zero-extended otherwise.
REQ-022 out_last SHALL equal (idx == N-1) whenever out_valid=1.
REQ-023 Transfer SHALL occur on a cycle with out_valid && out_ready; otherwise out_data, out_idx and out_last SHALL hold stable.
REQ-024 On a non-last transfer, idx SHALL increment by 1 and the next lane SHALL be presented the following cycle; there SHALL be no bubble.
REQ-025 On the last transfer with z_valid=0, the FSM SHALL go to IDLE and out_valid SHALL be 0 the next cycle.
REQ-026 On the last transfer with z_valid=1 in the same cycle, the block SHALL capture the new word and stay in DRAIN with idx=0, giving back-to-back output with no bubble.
REQ-027 z_valid=1 in DRAIN on any cycle other than a last transfer SHALL drop that word, set overrun=1 and leave the current drain undisturbed.
REQ-028 overrun SHALL stay set until rst.
REQ-029 For N=1 (8b x 8b), the drain SHALL be a single beat with out_last=1 and idx=0.
REQ-030 busy SHALL be 1 exactly when the FSM is in DRAIN.
REQ-031 Throughput SHALL be one lane per cycle with out_ready held high, giving a latency of 1 cycle from z_valid to the first out_valid.

Reset
REQ-032 When rst=1 the block SHALL enter IDLE and clear out_valid=0, out_last=0, out_idx=0, out_data=0, busy=0, overrun=0, the captured word and idx.
REQ-033 rst SHALL take priority over z_valid and over handshakes.
REQ-034 A reset during DRAIN SHALL abort the drain with no further beats.
REQ-035 z_valid asserted in the reset cycle SHALL be ignored.

Verification (Z_WIDTH=64, SIGNED=1)
REQ-036 Case 8x8: prec=0000, z=64'h8000_0000_0000_0001, z_valid pulse, out_ready=1 -> one beat: out_data=z, idx=0, out_last=1; out_valid low on the following cycle.
REQ-037 Case 4x4: prec=1010, z=64'hFFFF_0003_7FFF_8000 -> 4 beats, idx 0..3: out_data = sext(16'h8000), 16'h7FFF, 16'h0003, 16'hFFFF = -1; out_last only on idx 3.
REQ-038 Case 2x2: prec=1111, out_ready toggling 1,0,1,0 -> 16 beats of 4-bit lanes in order; data held stable while out_ready=0; no lane lost or duplicated.
REQ-039 Case back-to-back: z_valid coincident with the last transfer of word A -> word B idx 0 presented on the next cycle; overrun=0.
REQ-040 Case overrun and reset: z_valid at idx=1 of a 4-lane drain -> overrun=1 and the drain completes with the original data; then rst mid-drain -> out_valid=0, busy=0 and overrun=0 on the next cycle.
